control_sequencer: RTL

Hardwired microstep control unit for the single-bus datapath. It drives every datapath control strobe per T-state (fetch T0–T2, execute T3–T7) from the IR opcode. It supersedes bench-driven fixed sequences: it is parametrised in opcode width, step counter width and memory timeout, decodes instruction classes, stretches memory steps on a ready handshake, and detects memory timeout.

---
 rtl/control_sequencer.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/control_sequencer.sv
// Hardwired microstep control unit for the single-bus datapath.
// Decodes the IR opcode into per-T-state strobes, stretching memory steps on mem_ready.
module control_sequencer #(
    parameter int unsigned          OPCODE_W    = 5,
    parameter int unsigned          STEP_W      = 4,
    parameter logic [OPCODE_W-1:0]  OP_LD       = 5'b00000,
    parameter logic [OPCODE_W-1:0]  OP_ST       = 5'b00010,
    parameter logic [OPCODE_W-1:0]  OP_ADD      = 5'b00011,
    parameter logic [OPCODE_W-1:0]  ALU_R_LO    = 5'b00011,
    parameter logic [OPCODE_W-1:0]  ALU_R_HI    = 5'b01011,
    parameter logic [OPCODE_W-1:0]  ALU_I_LO    = 5'b01100,
    parameter logic [OPCODE_W-1:0]  ALU_I_HI    = 5'b01110,
    parameter logic [OPCODE_W-1:0]  OP_HALT     = 5'b11011,
    parameter int unsigned          MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ir_opcode,
    input  logic                mem_ready,
    output logic                PCout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                Cout,
    output logic                BAout,
    output logic                Rout,
    output logic                PCin,
    output logic                MARin,
    output logic                MDRin,
    output logic                IRin,
    output logic                Yin,
    output logic                Zin,
    output logic                Rin,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                IncPC,
    output logic                Read,
    output logic                Write,
    output logic [OPCODE_W-1:0] Operator,
    output logic [STEP_W-1:0]   step,
    output logic                instr_done,
    output logic                halted,
    output logic                fault
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_T7    = 4'd8,
        S_HALT  = 4'd14,
        S_FAULT = 4'd15
    } state_t;

    localparam int unsigned     CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_t               state, next_state;
    logic [CNT_W-1:0]     wait_cnt;
    logic                 is_ld, is_st, is_halt, is_alur, is_alui, is_alu;
    logic                 mem_wait, timeout;
    logic [OPCODE_W-1:0]  imm_op;

    // Class decode with priority LD > ST > HALT > ALU_R > ALU_I.
    assign is_ld   = (ir_opcode == OP_LD);
    assign is_st   = !is_ld && (ir_opcode == OP_ST);
    assign is_halt = !is_ld && !is_st && (ir_opcode == OP_HALT);
    assign is_alur = !is_ld && !is_st && !is_halt &&
                     (ir_opcode >= ALU_R_LO) && (ir_opcode <= ALU_R_HI);
    assign is_alui = !is_ld && !is_st && !is_halt && !is_alur &&
                     (ir_opcode >= ALU_I_LO) && (ir_opcode <= ALU_I_HI);
    assign is_alu  = is_alur || is_alui;
    assign imm_op  = ALU_R_LO + (ir_opcode - ALU_I_LO);

    assign mem_wait = (state == S_T1) || (state == S_T6 && is_ld) || (state == S_T7 && is_st);
    assign timeout  = mem_wait && !mem_ready && (wait_cnt == CNT_LAST);

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            // Counter is nonzero only while stalled in a memory step.
            if (mem_wait && !mem_ready && !timeout)
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
        end
    end

    always_comb begin
        state_t done_next;
        done_next  = run ? S_T0 : S_IDLE;
        next_state = state;
        case (state)
            S_IDLE:  if (run) next_state = S_T0;
            S_T0:    next_state = S_T1;
            S_T1:    if (mem_ready) next_state = S_T2;
                     else if (timeout) next_state = S_FAULT;
            S_T2:    next_state = S_T3;
            S_T3:    if (is_halt) next_state = S_HALT;
                     else if (is_ld || is_st || is_alu) next_state = S_T4;
                     else next_state = done_next;
            S_T4:    next_state = S_T5;
            S_T5:    next_state = is_alu ? done_next : S_T6;
            S_T6:    if (!is_ld || mem_ready) next_state = S_T7;
                     else if (timeout) next_state = S_FAULT;
            S_T7:    if (is_ld || mem_ready) next_state = done_next;
                     else if (timeout) next_state = S_FAULT;
            S_HALT:  next_state = S_HALT;
            S_FAULT: next_state = S_FAULT;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        PCout = 1'b0; Zlowout = 1'b0; MDRout = 1'b0; Cout = 1'b0; BAout = 1'b0; Rout = 1'b0;
        PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; Rin = 1'b0;
        Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; IncPC = 1'b0; Read = 1'b0; Write = 1'b0;
        Operator   = '0;
        instr_done = 1'b0;
        step       = STEP_W'(state);
        halted     = (state == S_HALT) || (state == S_FAULT);
        fault      = (state == S_FAULT);
        case (state)
            S_T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; Operator = OP_ADD;
            end
            S_T1: begin
                Read  = 1'b1;
                MDRin = mem_ready;
                // A zero wait count marks the first T1 cycle; PC update happens only once.
                if (wait_cnt == '0) begin
                    Zlowout = 1'b1; PCin = 1'b1;
                end
            end
            S_T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            S_T3: begin
                if (is_ld || is_st) begin
                    Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                end else if (is_alu) begin
                    Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                end else begin
                    instr_done = 1'b1;
                end
            end
            S_T4: begin
                Zin = 1'b1;
                if (is_alur) begin
                    Grc = 1'b1; Rout = 1'b1; Operator = ir_opcode;
                end else if (is_alui) begin
                    Cout = 1'b1; Operator = imm_op;
                end else begin
                    Cout = 1'b1; Operator = OP_ADD;
                end
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_alu) begin
                    Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
                end else begin
                    MARin = 1'b1;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    Read = 1'b1; MDRin = mem_ready;
                end else begin
                    Gra = 1'b1; BAout = 1'b1; MDRin = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; instr_done = 1'b1;
                end else begin
                    Write = 1'b1; instr_done = mem_ready;
                end
            end
            default: ;
        endcase
    end

endmodule
